regfile_scoreboard: RTL and testbench
=====================================

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, the register data width.
REQ-002 The block SHALL have parameter ADDR_W, default 5, the register address width; depth = 2**ADDR_W.
REQ-003 The block SHALL have parameter ZERO_REG, default 1; when 1, register 0 is hardwired to zero.
REQ-004 The block SHALL have port clock, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1 bit, an asynchronous active-low reset.
REQ-006 The block SHALL have port w_address_s1, input, ADDR_W bits, read port 1 address.
REQ-007 The block SHALL have port w_address_s2, input, ADDR_W bits, read port 2 address.
REQ-008 The block SHALL have port w_data_s1val, output, DATA_W bits, read port 1 data.
REQ-009 The block SHALL have port w_data_s2val, output, DATA_W bits, read port 2 data.
REQ-010 The block SHALL have port w_wr_en, input, 1 bit, writeback enable.
REQ-011 The block SHALL have port w_address_d, input, ADDR_W bits, writeback address.
REQ-012 The block SHALL have port w_data_dval, input, DATA_W bits, writeback data.
REQ-013 The block SHALL have port w_issue_en, input, 1 bit, marking that an issued instruction will later write w_issue_addr.
REQ-014 The block SHALL have port w_issue_addr, input, ADDR_W bits, destination of the issued instruction.
REQ-015 The block SHALL have port w_stall, output, 1 bit, a source operand awaiting writeback.
REQ-016 The block SHALL have port w_pending, output, 2**ADDR_W bits, the registered per-register pending vector.

Function
REQ-017 Reads SHALL be combinational: w_data_sNval = reg[w_address_sN], zero latency.
REQ-018 On w_wr_en=1 with w_address_d==w_address_sN, w_data_sNval SHALL equal w_data_dval in the same cycle (write-through bypass).
REQ-019 When ZERO_REG=1, reads of address 0 SHALL return 0, bypass included, and writes to address 0 SHALL be discarded.
REQ-020 On a rising edge with w_wr_en=1, reg[w_address_d] SHALL take w_data_dval; when w_wr_en=0, no register changes.
REQ-021 On a rising edge with w_issue_en=1, pending[w_issue_addr] SHALL be set to 1, except address 0 when ZERO_REG=1.
REQ-022 On a rising edge with w_wr_en=1, pending[w_address_d] SHALL clear to 0.
REQ-023 If issue and writeback target the same address in one cycle, set SHALL win; pending stays 1.
REQ-024 A repeat issue to an already-pending register SHALL leave it 1; the first later writeback clears it.
REQ-025 w_stall SHALL be combinational: 1 iff some port N has pending[w_address_sN]=1 and no same-cycle writeback to w_address_sN.
REQ-026 Address 0 SHALL never cause a stall when ZERO_REG=1.

Reset
REQ-027 While reset_n=0, all registers and the pending vector SHALL be 0, w_stall 0, both read ports 0, bypass disabled, writes and issues ignored.
REQ-028 Reset assertion mid-operation SHALL take effect immediately, without waiting for a clock edge.
REQ-029 The first edge after reset_n rises SHALL process w_wr_en and w_issue_en normally.

Structure
REQ-030 Package regfile_pkg SHALL hold default DATA_W, ADDR_W, ZERO_REG constants and the depth derivation.
REQ-031 The pending vector and stall logic SHALL be sub-module regfile_pending, instantiated once.

Verification
REQ-032 Reset, then read s1=3, s2=31 -> both 0, w_stall=0, w_pending=0.
REQ-033 Write 0xDEADBEEF to r7, read s1=7 same cycle -> 0xDEADBEEF via bypass; read again next cycle -> 0xDEADBEEF from storage.
REQ-034 Write 0x12345678 to r0, read s1=0 -> 0; issue r0 -> w_pending[0]=0, no stall.
REQ-035 Issue r5, next cycle s2=5 -> w_stall=1; writeback r5=0x55 -> same cycle w_stall=0, s2=0x55; next cycle pending[5]=0.
REQ-036 Issue r9 and writeback r9 in one cycle -> pending[9]=1 after the edge; a later writeback to r9 clears it.
REQ-037 With r4=0xA and pending[4]=1, pulse reset_n low between edges -> outputs 0 asynchronously; after release, r4 reads 0 and w_pending=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults and the depth derivation for the register file scoreboard.
package regfile_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int ADDR_W_DEF   = 5;
    localparam int ZERO_REG_DEF = 1;

    // Number of architectural registers addressed by an addr_w-bit index.
    function automatic int regfile_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Read-address, writeback and issue signals seen by the pending tracker,
// plus the stall and pending results it returns.
interface regfile_scoreboard_if
    import regfile_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
);

    localparam int DEPTH = regfile_depth(ADDR_W);

    logic [ADDR_W-1:0] addr_s1;
    logic [ADDR_W-1:0] addr_s2;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic              issue_en;
    logic [ADDR_W-1:0] issue_addr;
    logic              stall;
    logic [DEPTH-1:0]  pending;

    modport master (
        output addr_s1, addr_s2, wr_en, wr_addr, issue_en, issue_addr,
        input  stall, pending
    );

    modport slave (
        input  addr_s1, addr_s2, wr_en, wr_addr, issue_en, issue_addr,
        output stall, pending
    );

endinterface

// File: rtl/regfile_pending.sv
// Per-register pending bits and source-operand stall detection.
module regfile_pending
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = ZERO_REG_DEF
) (
    input  logic                 clock,
    input  logic                 reset_n,
    regfile_scoreboard_if.slave  bus
);

    localparam int DEPTH = regfile_depth(ADDR_W);
    localparam bit ZR    = (ZERO_REG != 0);

    logic [DEPTH-1:0] pending_q;
    logic [DEPTH-1:0] pending_d;
    logic             hit_s1;
    logic             hit_s2;

    // Next pending vector: writeback clears first so a same-cycle issue wins.
    always_comb begin
        pending_d = pending_q;
        if (bus.wr_en) begin
            pending_d[bus.wr_addr] = 1'b0;
        end
        if (bus.issue_en && !(ZR && bus.issue_addr == '0)) begin
            pending_d[bus.issue_addr] = 1'b1;
        end
    end

    // Pending register with asynchronous clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // Stall when a source is pending and not being written back this cycle.
    always_comb begin
        hit_s1 = pending_q[bus.addr_s1]
               && !(bus.wr_en && bus.wr_addr == bus.addr_s1)
               && !(ZR && bus.addr_s1 == '0);
        hit_s2 = pending_q[bus.addr_s2]
               && !(bus.wr_en && bus.wr_addr == bus.addr_s2)
               && !(ZR && bus.addr_s2 == '0);
        bus.stall = reset_n && (hit_s1 || hit_s2);
    end

    assign bus.pending = pending_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Two-read/one-write register file with write-through bypass and a
// pending-writeback scoreboard that raises a stall on unresolved sources.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = ZERO_REG_DEF
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic [ADDR_W-1:0]                w_address_s1,
    input  logic [ADDR_W-1:0]                w_address_s2,
    output logic [DATA_W-1:0]                w_data_s1val,
    output logic [DATA_W-1:0]                w_data_s2val,
    input  logic                             w_wr_en,
    input  logic [ADDR_W-1:0]                w_address_d,
    input  logic [DATA_W-1:0]                w_data_dval,
    input  logic                             w_issue_en,
    input  logic [ADDR_W-1:0]                w_issue_addr,
    output logic                             w_stall,
    output logic [regfile_depth(ADDR_W)-1:0] w_pending
);

    localparam int DEPTH = regfile_depth(ADDR_W);
    localparam bit ZR    = (ZERO_REG != 0);

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic              wr_accept;

    regfile_scoreboard_if #(.ADDR_W(ADDR_W)) pend_bus ();

    assign pend_bus.addr_s1    = w_address_s1;
    assign pend_bus.addr_s2    = w_address_s2;
    assign pend_bus.wr_en      = w_wr_en;
    assign pend_bus.wr_addr    = w_address_d;
    assign pend_bus.issue_en   = w_issue_en;
    assign pend_bus.issue_addr = w_issue_addr;
    assign w_stall             = pend_bus.stall;
    assign w_pending           = pend_bus.pending;

    regfile_pending #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_pending (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (pend_bus.slave)
    );

    assign wr_accept = w_wr_en && !(ZR && w_address_d == '0);

    // Register storage; writes to the hardwired zero register are dropped.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_accept) begin
            regs_q[w_address_d] <= w_data_dval;
        end
    end

    // Combinational read ports with write-through bypass, forced to zero in reset.
    always_comb begin
        w_data_s1val = '0;
        w_data_s2val = '0;
        if (reset_n) begin
            if (ZR && w_address_s1 == '0) begin
                w_data_s1val = '0;
            end else if (w_wr_en && w_address_d == w_address_s1) begin
                w_data_s1val = w_data_dval;
            end else begin
                w_data_s1val = regs_q[w_address_s1];
            end
            if (ZR && w_address_s2 == '0) begin
                w_data_s2val = '0;
            end else if (w_wr_en && w_address_d == w_address_s2) begin
                w_data_s2val = w_data_dval;
            end else begin
                w_data_s2val = regs_q[w_address_s2];
            end
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench for regfile_scoreboard: each driven cycle pushes the
// expected read data, stall and pending vector; the negedge monitor pops them.
module tb_regfile_scoreboard;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    typedef struct {
        string          tag;
        logic [DW-1:0]  d1;
        logic [DW-1:0]  d2;
        logic           st;
        logic [DEPTH-1:0] pend;
    } exp_t;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic [DW-1:0] data_s1, data_s2, data_d;

    regfile_scoreboard_if #(.ADDR_W(AW)) ifc ();

    regfile_scoreboard #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .ZERO_REG (1)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .w_address_s1 (ifc.addr_s1),
        .w_address_s2 (ifc.addr_s2),
        .w_data_s1val (data_s1),
        .w_data_s2val (data_s2),
        .w_wr_en      (ifc.wr_en),
        .w_address_d  (ifc.wr_addr),
        .w_data_dval  (data_d),
        .w_issue_en   (ifc.issue_en),
        .w_issue_addr (ifc.issue_addr),
        .w_stall      (ifc.stall),
        .w_pending    (ifc.pending)
    );

    always #5 clock = ~clock;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    exp_t        exp_q[$];

    logic [DW-1:0]    mdl_regs [DEPTH];
    logic [DEPTH-1:0] mdl_pend;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [DW-1:0] mdl_read(input logic [AW-1:0] a, input logic we,
                                               input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        if (a == 0) return '0;
        if (we && wa == a) return wd;
        return mdl_regs[a];
    endfunction

    function automatic logic mdl_src_stall(input logic [AW-1:0] a, input logic we,
                                           input logic [AW-1:0] wa);
        return (a != 0) && mdl_pend[a] && !(we && wa == a);
    endfunction

    task automatic mdl_reset();
        for (int i = 0; i < DEPTH; i++) mdl_regs[i] = '0;
        mdl_pend = '0;
    endtask

    // Drive one cycle of stimulus just after a rising edge and queue expectations.
    task automatic drive(input string tag,
                         input logic [AW-1:0] s1, input logic [AW-1:0] s2,
                         input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic ie, input logic [AW-1:0] ia);
        exp_t e;
        @(posedge clock);
        #1;
        ifc.addr_s1 = s1;  ifc.addr_s2 = s2;
        ifc.wr_en = we;    ifc.wr_addr = wa;   data_d = wd;
        ifc.issue_en = ie; ifc.issue_addr = ia;
        e.tag  = tag;
        e.d1   = mdl_read(s1, we, wa, wd);
        e.d2   = mdl_read(s2, we, wa, wd);
        e.st   = mdl_src_stall(s1, we, wa) || mdl_src_stall(s2, we, wa);
        e.pend = mdl_pend;
        exp_q.push_back(e);
        if (we && wa != 0) mdl_regs[wa] = wd;
        if (we) mdl_pend[wa] = 1'b0;
        if (ie && ia != 0) mdl_pend[ia] = 1'b1;
    endtask

    // Monitor: compare queued expectations half a cycle after the driving edge.
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check_eq({e.tag, ".s1"},   64'(data_s1),     64'(e.d1));
            check_eq({e.tag, ".s2"},   64'(data_s2),     64'(e.d2));
            check_eq({e.tag, ".stall"}, 64'(ifc.stall),  64'(e.st));
            check_eq({e.tag, ".pend"}, 64'(ifc.pending), 64'(e.pend));
        end
    end

    // Pull reset low between edges and check that outputs clear without a clock.
    task automatic async_reset_pulse();
        @(posedge clock);
        #6;
        ifc.wr_en = 1'b0;
        ifc.issue_en = 1'b0;
        check_eq("pre_rst.s1", 64'(data_s1), 64'(mdl_read(ifc.addr_s1, 1'b0, '0, '0)));
        check_eq("pre_rst.stall", 64'(ifc.stall), 64'(mdl_src_stall(ifc.addr_s1, 1'b0, '0)
                                                      || mdl_src_stall(ifc.addr_s2, 1'b0, '0)));
        reset_n = 1'b0;
        #1;
        check_eq("async_rst.s1",    64'(data_s1),     64'h0);
        check_eq("async_rst.stall", 64'(ifc.stall),   64'h0);
        check_eq("async_rst.pend",  64'(ifc.pending), 64'h0);
        mdl_reset();
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        mdl_reset();
        ifc.addr_s1 = 5'd3;  ifc.addr_s2 = 5'd31;
        ifc.wr_en = 1'b1;    ifc.wr_addr = 5'd3;   data_d = 32'hFFFF_FFFF;
        ifc.issue_en = 1'b1; ifc.issue_addr = 5'd3;

        // In reset: bypass disabled, writes and issues ignored.
        #12;
        check_eq("in_rst.s1",    64'(data_s1),     64'h0);
        check_eq("in_rst.s2",    64'(data_s2),     64'h0);
        check_eq("in_rst.stall", 64'(ifc.stall),   64'h0);
        check_eq("in_rst.pend",  64'(ifc.pending), 64'h0);
        ifc.wr_en = 1'b0;
        ifc.issue_en = 1'b0;
        #6;
        reset_n = 1'b1;

        drive("post_rst", 5'd3, 5'd31, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);

        drive("wr7_bypass", 5'd7, 5'd0, 1'b1, 5'd7, 32'hDEAD_BEEF, 1'b0, 5'd0);
        drive("rd7_store",  5'd7, 5'd7, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0);

        drive("wr0",      5'd0, 5'd0, 1'b1, 5'd0, 32'h1234_5678, 1'b0, 5'd0);
        drive("issue0",   5'd0, 5'd0, 1'b0, 5'd0, 32'h0,         1'b1, 5'd0);
        drive("after_i0", 5'd0, 5'd0, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0);

        drive("issue5",   5'd0, 5'd0, 1'b0, 5'd0, 32'h0,  1'b1, 5'd5);
        drive("stall5",   5'd0, 5'd5, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0);
        drive("wb5",      5'd0, 5'd5, 1'b1, 5'd5, 32'h55, 1'b0, 5'd0);
        drive("clear5",   5'd0, 5'd5, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0);

        drive("iss_wb9",  5'd0, 5'd0, 1'b1, 5'd9, 32'h99,  1'b1, 5'd9);
        drive("held9",    5'd9, 5'd0, 1'b0, 5'd0, 32'h0,   1'b0, 5'd0);
        drive("wb9",      5'd9, 5'd0, 1'b1, 5'd9, 32'h999, 1'b0, 5'd0);
        drive("clear9",   5'd9, 5'd0, 1'b0, 5'd0, 32'h0,   1'b0, 5'd0);

        drive("iss12a",   5'd0, 5'd0,  1'b0, 5'd0,  32'h0,  1'b1, 5'd12);
        drive("iss12b",   5'd12, 5'd0, 1'b0, 5'd0,  32'h0,  1'b1, 5'd12);
        drive("wb12",     5'd12, 5'd0, 1'b1, 5'd12, 32'hC0, 1'b0, 5'd0);
        drive("clear12",  5'd12, 5'd0, 1'b0, 5'd0,  32'h0,  1'b0, 5'd0);

        drive("wr_iss4",  5'd0, 5'd0, 1'b1, 5'd4, 32'hA, 1'b1, 5'd4);
        drive("stall4",   5'd4, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        async_reset_pulse();
        drive("rd4_after_rst", 5'd4, 5'd4, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        drive("first_edge",    5'd6, 5'd0, 1'b1, 5'd6, 32'h66, 1'b1, 5'd6);
        drive("first_edge_q",  5'd6, 5'd0, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0);

        for (int n = 0; n < 60; n++) begin
            drive("rand",
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
        end
        drive("idle", 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clock);
        #1;
        check_eq("drain", 64'(exp_q.size()), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
